// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: bus geometry, tag field layout, client ids and FSM
// states shared by the cache-to-bus memory arbiter and its line buffer.
package mem_bus_pkg;

  localparam int BusWidth  = 64;
  localparam int LineWidth = 512;
  localparam int TagWidth  = 13;
  localparam int Beats     = LineWidth / BusWidth;
  localparam int BeatBits  = $clog2(Beats);

  localparam logic [3:0] CmdMemory = 4'b0001;

  localparam int TAG_WRITE_BIT = 12;
  localparam int TAG_CMD_HI    = 11;
  localparam int TAG_CMD_LO    = 8;
  localparam int TAG_ID_HI     = 7;
  localparam int TAG_ID_LO     = 0;

  localparam logic [7:0] ID_I = 8'h00;
  localparam logic [7:0] ID_D = 8'h01;

  localparam logic [BeatBits-1:0] LastBeat =
    BeatBits'(Beats - 1);

  localparam logic [BusWidth-1:0] LineMask =
    ~BusWidth'(LineWidth / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RRESP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [TagWidth-1:0] mk_tag(
    input logic       wr,
    input logic [7:0] id
  );
    logic [TagWidth-1:0] t;
    t                        = '0;
    t[TAG_WRITE_BIT]         = wr;
    t[TAG_CMD_HI:TAG_CMD_LO] = CmdMemory;
    t[TAG_ID_HI:TAG_ID_LO]   = id;
    return t;
  endfunction

endpackage

// File: rtl/line_shift_buf.sv
// line_shift_buf: one cache line held as bus beats with a beat counter.
// Ports: load_i/load_data_i parallel load (counter to 0); put_i/put_data_i
// store a beat at the counter and advance; adv_i advance only;
// beat_o counter, beat_data_o current beat, line_d_o next-state line.
module line_shift_buf
  import mem_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [LineWidth-1:0] load_data_i,
  input  logic                 put_i,
  input  logic [BusWidth-1:0]  put_data_i,
  input  logic                 adv_i,
  output logic [BeatBits-1:0]  beat_o,
  output logic [BusWidth-1:0]  beat_data_o,
  output logic [LineWidth-1:0] line_d_o
);

  logic [LineWidth-1:0] line_q, line_d;
  logic [BeatBits-1:0]  beat_q, beat_d;

  always_comb begin
    line_d = line_q;
    beat_d = beat_q;
    if (load_i) begin
      line_d = load_data_i;
      beat_d = '0;
    end else if (put_i) begin
      line_d[BusWidth*beat_q +: BusWidth] = put_data_i;
      beat_d = beat_q + 1'b1;
    end else if (adv_i) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
      beat_q <= '0;
    end else begin
      line_q <= line_d;
      beat_q <= beat_d;
    end
  end

  assign beat_o      = beat_q;
  assign beat_data_o = line_q[BusWidth*beat_q +: BusWidth];
  assign line_d_o    = line_d;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges I-cache and D-cache line requests onto one tagged
// 64-bit bus, one transaction at a time, round-robin on ties.
// Ports: i*/d* client handshakes (request/reqack/done, line data),
// bus_req* request beats, bus_resp* response beats, bus_respack consume.
module mem_arbiter
  import mem_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 irequest,
  output logic                 ireqack,
  input  logic [BusWidth-1:0]  iaddr,
  output logic [LineWidth-1:0] irdata,
  output logic                 idone,
  input  logic                 drequest,
  output logic                 dreqack,
  input  logic                 dwrenable,
  input  logic [BusWidth-1:0]  daddr,
  input  logic [LineWidth-1:0] dwdata,
  output logic [LineWidth-1:0] drdata,
  output logic                 ddone,
  output logic                 bus_reqcyc,
  output logic [BusWidth-1:0]  bus_req,
  output logic [TagWidth-1:0]  bus_reqtag,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [BusWidth-1:0]  bus_resp,
  input  logic [TagWidth-1:0]  bus_resptag,
  output logic                 bus_respack
);

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                wr_q, wr_d;
  logic [BusWidth-1:0] addr_q, addr_d;
  logic                iack_q, iack_d;
  logic                dack_q, dack_d;
  logic [LineWidth-1:0] irdata_q, drdata_q;

  logic                 pick_d;
  logic                 buf_load, buf_put, buf_adv;
  logic [LineWidth-1:0] buf_load_data;
  logic [BeatBits-1:0]  beat;
  logic [BusWidth-1:0]  beat_data;
  logic [LineWidth-1:0] line_d;
  logic [TagWidth-1:0]  tag;
  logic                 tag_hit;
  logic                 fill_last;

  // gnt/last: 1 = D-cache, 0 = I-cache
  assign tag     = mk_tag(wr_q, gnt_q ? ID_D : ID_I);
  assign tag_hit = bus_respcyc && (bus_resptag == tag);

  line_shift_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .load_i      (buf_load),
    .load_data_i (buf_load_data),
    .put_i       (buf_put),
    .put_data_i  (bus_resp),
    .adv_i       (buf_adv),
    .beat_o      (beat),
    .beat_data_o (beat_data),
    .line_d_o    (line_d)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    iack_d        = 1'b0;
    dack_d        = 1'b0;
    pick_d        = 1'b0;
    buf_load      = 1'b0;
    buf_load_data = '0;
    buf_put       = 1'b0;
    buf_adv       = 1'b0;
    bus_respack   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // D wins unless I also asks and D was served last
        pick_d = drequest && (!irequest || !last_q);
        if (irequest || drequest) begin
          gnt_d    = pick_d;
          last_d   = pick_d;
          wr_d     = pick_d && dwrenable;
          addr_d   = (pick_d ? daddr : iaddr) & LineMask;
          buf_load = 1'b1;
          if (pick_d && dwrenable) buf_load_data = dwdata;
          iack_d   = !pick_d;
          dack_d   = pick_d;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus_reqack) state_d = wr_q ? S_WDATA : S_RRESP;
      end
      S_WDATA: begin
        if (bus_reqack) begin
          buf_adv = 1'b1;
          if (beat == LastBeat) state_d = S_DONE;
        end
      end
      S_RRESP: begin
        if (tag_hit) begin
          bus_respack = 1'b1;
          buf_put     = 1'b1;
          if (beat == LastBeat) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // rdata is captured on the edge that stores the last beat so it is
  // already valid during the done pulse
  assign fill_last = buf_put && (beat == LastBeat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      iack_q  <= iack_d;
      dack_q  <= dack_d;
      if (fill_last && gnt_q)  drdata_q <= line_d;
      if (fill_last && !gnt_q) irdata_q <= line_d;
    end
  end

  assign ireqack = iack_q;
  assign dreqack = dack_q;
  assign irdata  = irdata_q;
  assign drdata  = drdata_q;
  assign idone   = (state_q == S_DONE) && !gnt_q;
  assign ddone   = (state_q == S_DONE) && gnt_q;

  always_comb begin
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    bus_reqtag = '0;
    if (state_q == S_ADDR) begin
      bus_reqcyc = 1'b1;
      bus_req    = addr_q;
      bus_reqtag = tag;
    end else if (state_q == S_WDATA) begin
      bus_reqcyc = 1'b1;
      bus_req    = beat_data;
      bus_reqtag = tag;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with immediate
// assertions against hand-computed values.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         irequest;
  logic         ireqack;
  logic [63:0]  iaddr;
  logic [511:0] irdata;
  logic         idone;
  logic         drequest;
  logic         dreqack;
  logic         dwrenable;
  logic [63:0]  daddr;
  logic [511:0] dwdata;
  logic [511:0] drdata;
  logic         ddone;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack;
  logic         bus_respcyc;
  logic [63:0]  bus_resp;
  logic [12:0]  bus_resptag;
  logic         bus_respack;

  int checks   = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .irequest    (irequest),
    .ireqack     (ireqack),
    .iaddr       (iaddr),
    .irdata      (irdata),
    .idone       (idone),
    .drequest    (drequest),
    .dreqack     (dreqack),
    .dwrenable   (dwrenable),
    .daddr       (daddr),
    .dwdata      (dwdata),
    .drdata      (drdata),
    .ddone       (ddone),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        tag,
    input logic [511:0] obs,
    input logic [511:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkline(input logic [63:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = base + 64'(i);
    return l;
  endfunction

  // entered in the cycle after reqack (state ADDR); leaves in DONE
  task automatic serve_read(input logic [12:0] tg, input logic [63:0] base);
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_respcyc = 1'b1;
      bus_resptag = tg;
      bus_resp    = base + 64'(i);
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    #1;
  endtask

  logic [511:0] wline;
  logic [63:0]  exp_beat;
  int           nbeats;

  initial begin
    reset = 1'b1;
    irequest = 0; iaddr = '0;
    drequest = 0; dwrenable = 0; daddr = '0; dwdata = '0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_reqcyc", 512'(bus_reqcyc), 512'd0);
    chk("rst_req", 512'(bus_req), 512'd0);
    chk("rst_reqtag", 512'(bus_reqtag), 512'd0);
    chk("rst_acks", 512'({ireqack, dreqack, idone, ddone}), 512'd0);
    chk("rst_irdata", irdata, 512'd0);
    chk("rst_drdata", drdata, 512'd0);

    // D read
    drequest = 1; daddr = 64'h1047;
    tick();
    chk("rd_dreqack", 512'({dreqack, ireqack}), 512'b10);
    drequest = 0;
    #1;
    chk("rd_addr", 512'(bus_req), 512'h1040);
    chk("rd_tag", 512'(bus_reqtag), 512'h0101);
    chk("rd_reqcyc", 512'(bus_reqcyc), 512'd1);
    bus_reqack = 1;
    tick();
    bus_reqack = 0;
    #1;
    chk("rd_reqcyc_off", 512'(bus_reqcyc), 512'd0);
    for (int i = 0; i < 8; i++) begin
      bus_respcyc = 1; bus_resptag = 13'h0101; bus_resp = 64'h1000 + 64'(i);
      #1;
      chk("rd_respack", 512'(bus_respack), 512'd1);
      chk("rd_no_early_done", 512'(ddone), 512'd0);
      tick();
    end
    bus_respcyc = 0;
    #1;
    chk("rd_ddone", 512'(ddone), 512'd1);
    chk("rd_drdata", drdata, mkline(64'h1000));
    tick();
    chk("rd_ddone_pulse", 512'(ddone), 512'd0);
    chk("rd_drdata_hold", drdata, mkline(64'h1000));

    // D write
    drequest = 1; dwrenable = 1; daddr = 64'h2000;
    dwdata = mkline(64'hA0);
    tick();
    chk("wr_dreqack", 512'(dreqack), 512'd1);
    drequest = 0; dwrenable = 0; dwdata = '0;
    for (int k = 0; k < 9; k++) begin
      bus_reqack = 1;
      #1;
      exp_beat = (k == 0) ? 64'h2000 : 64'hA0 + 64'(k - 1);
      chk("wr_beat", 512'(bus_req), 512'(exp_beat));
      chk("wr_tag", 512'(bus_reqtag), 512'h1101);
      chk("wr_reqcyc", 512'(bus_reqcyc), 512'd1);
      tick();
    end
    bus_reqack = 0;
    #1;
    chk("wr_ddone", 512'(ddone), 512'd1);
    chk("wr_reqcyc_off", 512'(bus_reqcyc), 512'd0);
    chk("wr_drdata_keep", drdata, mkline(64'h1000));
    tick();

    // tie after reset: D, I, D
    reset = 1;
    tick();
    reset = 0;
    irequest = 1; iaddr = 64'h4000;
    drequest = 1; daddr = 64'h3000;
    tick();
    chk("tie1_acks", 512'({dreqack, ireqack}), 512'b10);
    tick();
    chk("tie1_noreack", 512'({dreqack, ireqack}), 512'b00);
    chk("tie1_addr", 512'(bus_req), 512'h3000);
    serve_read(13'h0101, 64'h3100);
    chk("tie1_ddone", 512'(ddone), 512'd1);
    tick();
    tick();
    chk("tie2_acks", 512'({dreqack, ireqack}), 512'b01);
    chk("tie2_tag", 512'(bus_reqtag), 512'h0100);
    chk("tie2_addr", 512'(bus_req), 512'h4000);
    serve_read(13'h0100, 64'h4100);
    chk("tie2_idone", 512'({idone, ddone}), 512'b10);
    chk("tie2_irdata", irdata, mkline(64'h4100));
    tick();
    tick();
    chk("tie3_acks", 512'({dreqack, ireqack}), 512'b10);
    irequest = 0; drequest = 0;
    serve_read(13'h0101, 64'h5100);
    chk("tie3_drdata", drdata, mkline(64'h5100));
    tick();

    // stalled D write
    drequest = 1; dwrenable = 1; daddr = 64'h6010;
    wline = mkline(64'hB0);
    dwdata = wline;
    tick();
    chk("st_dreqack", 512'(dreqack), 512'd1);
    drequest = 0; dwrenable = 0; dwdata = '0;
    nbeats = 0;
    for (int c = 0; c < 5; c++) begin
      chk("st_addr_hold", 512'({bus_reqcyc, bus_reqtag, bus_req}),
          512'({1'b1, 13'h1101, 64'h6000}));
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      if (k == 4) begin
        for (int c = 0; c < 5; c++) begin
          chk("st_beat3_hold", 512'({bus_reqcyc, bus_reqtag, bus_req}),
              512'({1'b1, 13'h1101, 64'hB3}));
          tick();
        end
      end
      exp_beat = (k == 0) ? 64'h6000 : 64'hB0 + 64'(k - 1);
      chk("st_beat", 512'(bus_req), 512'(exp_beat));
      bus_reqack = 1;
      #1;
      if (bus_reqcyc) nbeats++;
      tick();
      bus_reqack = 0;
      #1;
    end
    chk("st_nbeats", 512'(nbeats), 512'd9);
    chk("st_ddone", 512'({ddone, bus_reqcyc}), 512'b10);
    tick();

    // stray response in IDLE, then foreign tag during RRESP
    bus_respcyc = 1; bus_resptag = 13'h0100; bus_resp = 64'hDEAD;
    #1;
    chk("idle_respack", 512'(bus_respack), 512'd0);
    bus_respcyc = 0;
    irequest = 1; iaddr = 64'h7008;
    tick();
    chk("fr_ireqack", 512'(ireqack), 512'd1);
    chk("fr_addr", 512'(bus_req), 512'h7000);
    irequest = 0;
    bus_reqack = 1;
    tick();
    bus_reqack = 0;
    for (int i = 0; i < 9; i++) begin
      bus_respcyc = 1;
      if (i == 2) begin
        bus_resptag = 13'h0105; bus_resp = 64'hBAD;
        #1;
        chk("fr_foreign_respack", 512'(bus_respack), 512'd0);
      end else begin
        bus_resptag = 13'h0100;
        bus_resp = 64'h7700 + 64'((i > 2) ? i - 1 : i);
        #1;
        chk("fr_respack", 512'(bus_respack), 512'd1);
      end
      tick();
    end
    bus_respcyc = 0;
    #1;
    chk("fr_idone", 512'(idone), 512'd1);
    chk("fr_irdata", irdata, mkline(64'h7700));
    tick();

    // reset after 3 read beats
    drequest = 1; daddr = 64'h8000;
    tick();
    drequest = 0;
    bus_reqack = 1;
    tick();
    bus_reqack = 0;
    for (int i = 0; i < 3; i++) begin
      bus_respcyc = 1; bus_resptag = 13'h0101; bus_resp = 64'h8800 + 64'(i);
      tick();
    end
    bus_respcyc = 0;
    reset = 1;
    tick();
    chk("mr_flags", 512'({ireqack, dreqack, idone, ddone, bus_reqcyc,
        bus_respack}), 512'd0);
    chk("mr_req", 512'({bus_reqtag, bus_req}), 512'd0);
    chk("mr_drdata", drdata, 512'd0);
    chk("mr_irdata", irdata, 512'd0);
    reset = 0;
    tick();
    chk("mr_no_ddone", 512'(ddone), 512'd0);
    irequest = 1; iaddr = 64'h9000;
    tick();
    chk("mr_ireqack", 512'(ireqack), 512'd1);
    chk("mr_tag", 512'({bus_reqtag, bus_req}), 512'({13'h0100, 64'h9000}));
    irequest = 0;
    serve_read(13'h0100, 64'h9100);
    chk("mr_idone", 512'(idone), 512'd1);
    chk("mr_irdata_new", irdata, mkline(64'h9100));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
